// File: rtl/mbox_pkg.sv
// Shared types and constants for the AHB mailbox monitor.
package mbox_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mbox_state_e;

  localparam int unsigned CH_CONSOLE = 0;
  localparam int unsigned CH_EXIT    = 1;
  localparam logic [7:0]  EXIT_PASS  = 8'hFF;
  localparam logic [7:0]  PRINT_LO   = 8'h20;
  localparam logic [7:0]  PRINT_HI   = 8'h7E;

  // Data-phase context captured at address acceptance
  typedef struct packed {
    logic       write;
    logic       hit;
    logic [3:0] ch;
    logic [1:0] off;
    logic [2:0] size;
  } mbox_dphase_t;

  // Byte lanes touched by a write within its 32-bit channel word
  function automatic logic [31:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    logic [31:0] m;
    case (size)
      3'd0:    m = 32'h0000_00FF << {off, 3'b000};
      3'd1:    m = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/ahb_mbox_monitor_if.sv
// AHB-Lite slave port bundle for the mailbox monitor.
interface ahb_mbox_monitor_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hsel;
  logic        hready;
  logic [63:0] hwdata;
  logic [63:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hsel, hready, hwdata,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hsel, hready, hwdata,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/mbox_fifo.sv
// Synchronous FIFO for console characters; pointers carry one wrap bit.
module mbox_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ahb_mbox_monitor.sv
// AHB-Lite mailbox: console FIFO, exit code, scratch channels and test watchdog.
// Optional read-back of channel state is compiled in with MBOX_RDBK_EN.
module ahb_mbox_monitor
  import mbox_pkg::*;
#(
  parameter logic [31:0] MBOX_BASE  = 32'hD058_0000,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] TIMEOUT    = 32'h800
) (
  input  logic                    clk,
  input  logic                    rst_l,
  ahb_mbox_monitor_if.slave       bus,
  output logic                    cons_valid,
  output logic [7:0]              cons_data,
  input  logic                    cons_ready,
  output logic                    test_done,
  output logic                    test_pass,
  output logic                    test_timeout,
  output logic [31:0]             cycle_cnt,
  output logic [32*NUM_CH-1:0]    scratch
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  mbox_dphase_t                dp_q;
  logic                        dp_valid_q;
  mbox_state_e                 state_q;
  logic [NUM_CH-1:0][31:0]     scratch_q;

  logic              accept;
  logic              hit;
  logic              dp_wr;
  logic [31:0]       wlane;
  logic [31:0]       wmask;
  logic [31:0]       wval;
  logic              push_req;
  logic              pop;
  logic              stall;
  logic              exit_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_ok;

  assign unused_ok = bus.htrans[0];

  // Address decode and data-phase write value
  assign hit    = (bus.haddr[31:6] == MBOX_BASE[31:6]) && (5'(bus.haddr[5:2]) < 5'(NUM_CH));
  assign accept = bus.hsel & bus.hready & bus.htrans[1] & ~stall;
  assign dp_wr  = dp_valid_q & dp_q.write & dp_q.hit;
  assign wlane  = dp_q.ch[0] ? bus.hwdata[63:32] : bus.hwdata[31:0];
  assign wmask  = lane_mask(dp_q.size, dp_q.off);
  assign wval   = wlane & wmask;

  // A printable console write into a full FIFO waits for a pop
  assign push_req = dp_wr && (dp_q.ch == 4'(CH_CONSOLE)) && is_printable(wval[7:0]);
  assign pop      = ~fifo_empty & cons_ready;
  assign stall    = push_req & fifo_full & ~pop;
  assign exit_wr  = dp_wr && (dp_q.ch == 4'(CH_EXIT)) && (wval != 32'd0);

  assign bus.hreadyout = ~stall;
  assign bus.hresp     = 1'b0;
  assign cons_valid    = ~fifo_empty;
  assign scratch       = scratch_q;

  mbox_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (push_req & ~stall),
    .pop   (pop),
    .wdata (wval[7:0]),
    .rdata (cons_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      dp_valid_q <= 1'b0;
      dp_q       <= '0;
    end else if (!stall) begin
      dp_valid_q <= accept;
      dp_q.write <= bus.hwrite;
      dp_q.hit   <= hit;
      dp_q.ch    <= bus.haddr[5:2];
      dp_q.off   <= bus.haddr[1:0];
      dp_q.size  <= bus.hsize;
    end
  end

  // Verdict FSM; an exit-code write takes priority over the watchdog
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q      <= ST_RUN;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
      test_timeout <= 1'b0;
      cycle_cnt    <= 32'd0;
    end else begin
      if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
      if (state_q == ST_RUN) begin
        if (exit_wr) begin
          state_q   <= (wval == 32'(EXIT_PASS)) ? ST_PASS : ST_FAIL;
          test_done <= 1'b1;
          test_pass <= (wval == 32'(EXIT_PASS));
        end else if ((TIMEOUT != 32'd0) && (cycle_cnt == TIMEOUT - 32'd1)) begin
          state_q      <= ST_TIMEOUT;
          test_done    <= 1'b1;
          test_timeout <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      scratch_q <= '0;
    end else begin
      for (int unsigned i = 2; i < NUM_CH; i++) begin
        if (dp_wr && (dp_q.ch == 4'(i))) scratch_q[i] <= (scratch_q[i] & ~wmask) | wval;
      end
    end
  end

`ifdef MBOX_RDBK_EN
  logic [31:0] rd_word;

  always_comb begin
    rd_word = 32'd0;
    if (dp_valid_q && !dp_q.write && dp_q.hit) begin
      if (dp_q.ch == 4'(CH_CONSOLE)) begin
        rd_word = {16'b0, 8'(fifo_count), 7'b0, fifo_full};
      end else if (dp_q.ch == 4'(CH_EXIT)) begin
        rd_word = {30'b0, state_q};
      end else begin
        for (int unsigned i = 2; i < NUM_CH; i++) begin
          if (dp_q.ch == 4'(i)) rd_word = scratch_q[i];
        end
      end
    end
    bus.hrdata = dp_q.ch[0] ? {rd_word, 32'b0} : {32'b0, rd_word};
  end
`else
  logic unused_rdbk;

  assign unused_rdbk = ^fifo_count;
  assign bus.hrdata  = 64'd0;
`endif

endmodule
